// File: rtl/pwm_capture_16bits_pkg.sv
// Shared types and constants for the PWM input-capture block.
// Optional glitch filter selected with `PWM_CAP_GLITCH_FILTER_EN (see the filter sub-module).
package pwm_capture_16bits_pkg;

    localparam int CAP_CNT_W        = 16;  // counter/result width in ticks
    localparam int CAP_DIV_W        = 5;   // prescaler / clk_divider width
    localparam int CAP_SYNC_STAGES  = 2;   // default synchronizer depth
    localparam int CAP_FILT_LEN     = 4;   // default glitch-filter length

    // Capture enable as seen on the pwm_onoff pin.
    typedef enum logic {
        PWM_OFF = 1'b0,
        PWM_ON  = 1'b1
    } pwm_onoff_e;

    // Capture sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,   // block held off
        ARM  = 2'd1,   // waiting for the first rising edge
        HIGH = 2'd2,   // input high, counting high time and period
        LOW  = 2'd3    // input low, high time held, counting period
    } cap_state_e;

    // Per-cycle datapath controls decoded from the sequencer state.
    typedef struct packed {
        logic clear_cnt;      // zero both interval counters
        logic count_per;      // advance the period counter on tick
        logic count_high;     // advance the high-time counter on tick
        logic publish;        // load result registers, strobe meas_valid
        logic set_timeout;    // raise the sticky timeout flag
        logic clear_timeout;  // drop the sticky timeout flag
        logic clear_presc;    // restart the prescaler phase
    } cap_ctrl_t;

    // True in the states where an interval is being measured.
    function automatic logic is_measuring(input cap_state_e s);
        return (s == HIGH) || (s == LOW);
    endfunction

endpackage

// File: rtl/pwm_capture_16bits_pwm_in_filter.sv
// Input conditioning for the capture block: synchronizer, optional glitch
// filter and single-cycle rise/fall strobes.
// `PWM_CAP_GLITCH_FILTER_EN defined: level changes only after FILT_LEN
// consecutive equal synchronized samples; shorter pulses are rejected.
module pwm_capture_16bits_pwm_in_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic pwm_in,
    output logic rise,
    output logic fall
);

    if (SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_param_check
        $error("pwm_in_filter: SYNC_STAGES must be >= 2 and FILT_LEN >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level;
    logic                   level_q;

    // Bring the asynchronous pin into the clk domain.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: clocked state always uses non-blocking assignment so every
        // flop samples the pre-edge value of its neighbours.
        if (!reset) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
    end

`ifdef PWM_CAP_GLITCH_FILTER_EN
    localparam int FC_W = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);

    logic [FC_W-1:0] filt_cnt;
    logic            filt_level;

    // Accept a new level only after FILT_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_cnt   <= '0;
            filt_level <= 1'b0;
        end else if (sync_q[SYNC_STAGES-1] == filt_level) begin
            filt_cnt   <= '0;
        end else if (filt_cnt == FC_W'(FILT_LEN - 1)) begin
            filt_cnt   <= '0;
            filt_level <= sync_q[SYNC_STAGES-1];
        end else begin
            filt_cnt   <= filt_cnt + FC_W'(1);
        end
    end

    assign level = filt_level;
`else
    assign level = sync_q[SYNC_STAGES-1];
`endif

    // Edge-detect flop: remembers the previous conditioned level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) level_q <= 1'b0;
        else        level_q <= level;
    end

    assign rise = level & ~level_q;
    assign fall = ~level & level_q;

endmodule

// File: rtl/pwm_capture_16bits.sv
// PWM input capture: measures period and high time of pwm_in in prescaled
// ticks and publishes them with a one-cycle meas_valid strobe. A sticky
// timeout flags an input that stops toggling.
// Optional glitch filter: define `PWM_CAP_GLITCH_FILTER_EN.
module pwm_capture_16bits
    import pwm_capture_16bits_pkg::*;
#(
    parameter int CNT_W       = CAP_CNT_W,
    parameter int SYNC_STAGES = CAP_SYNC_STAGES,
    parameter int FILT_LEN    = CAP_FILT_LEN
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pwm_in,
    input  logic [CAP_DIV_W-1:0] clk_divider,
    input  pwm_onoff_e           pwm_onoff,
    output logic [CNT_W-1:0]     period_out,
    output logic [CNT_W-1:0]     high_out,
    output logic                 meas_valid,
    output logic                 timeout
);

    logic                 rise;
    logic                 fall;
    logic                 tick;
    logic                 running;
    logic                 cnt_sat;
    logic [CAP_DIV_W-1:0] presc;
    logic [CNT_W-1:0]     cnt_per;
    logic [CNT_W-1:0]     cnt_high;
    cap_state_e           state;
    cap_state_e           next_state;
    cap_ctrl_t            ctrl;

    // Add one tick unless the counter is already pinned at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             inc);
        if (v == '1) return v;
        else         return v + {{(CNT_W-1){1'b0}}, inc};
    endfunction

    pwm_capture_16bits_pwm_in_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_in_filter (
        .clk    (clk),
        .reset  (reset),
        .pwm_in (pwm_in),
        .rise   (rise),
        .fall   (fall)
    );

    assign running = (pwm_onoff == PWM_ON);
    assign tick    = (presc == clk_divider);
    assign cnt_sat = (cnt_per == '1);

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Sequencer next state: timeout beats a same-cycle edge.
    always_comb begin
        next_state = state;
        if (!running) begin
            next_state = IDLE;
        end else begin
            unique case (state)
                IDLE: next_state = ARM;
                ARM:  if (rise) next_state = HIGH;
                HIGH: begin
                    if (cnt_sat)   next_state = ARM;
                    else if (fall) next_state = LOW;
                end
                LOW: begin
                    if (cnt_sat)   next_state = ARM;
                    else if (rise) next_state = HIGH;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Sequencer outputs: datapath controls for the current cycle.
    always_comb begin
        // NOTE: every field gets a default first so no path leaves a
        // combinational output unassigned (which would infer a latch).
        ctrl             = '0;
        ctrl.clear_presc = rise;
        if (!running) begin
            ctrl.clear_cnt     = 1'b1;
            ctrl.clear_presc   = 1'b1;
            ctrl.clear_timeout = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    ctrl.clear_cnt   = 1'b1;
                    ctrl.clear_presc = 1'b1;
                end
                ARM: begin
                    ctrl.clear_cnt = 1'b1;
                end
                HIGH: begin
                    if (cnt_sat) begin
                        ctrl.set_timeout = 1'b1;
                        ctrl.clear_cnt   = 1'b1;
                    end else begin
                        // The falling-edge cycle still counts its tick into
                        // the high time; LOW then holds that value.
                        ctrl.count_per  = 1'b1;
                        ctrl.count_high = 1'b1;
                    end
                end
                LOW: begin
                    if (cnt_sat) begin
                        ctrl.set_timeout = 1'b1;
                        ctrl.clear_cnt   = 1'b1;
                    end else if (rise) begin
                        ctrl.publish       = 1'b1;
                        ctrl.clear_timeout = 1'b1;
                        ctrl.clear_cnt     = 1'b1;
                    end else begin
                        ctrl.count_per = 1'b1;
                    end
                end
                default: ctrl.clear_cnt = 1'b1;
            endcase
        end
    end

    // Prescaler: one tick every clk_divider+1 clk, phase restarted on rise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                  presc <= '0;
        else if (ctrl.clear_presc)   presc <= '0;
        else if (tick)               presc <= '0;
        else                         presc <= presc + CAP_DIV_W'(1);
    end

    // Interval counters: period over the whole cycle, high time while high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_per  <= '0;
            cnt_high <= '0;
        end else if (ctrl.clear_cnt) begin
            cnt_per  <= '0;
            cnt_high <= '0;
        end else begin
            if (ctrl.count_per)  cnt_per  <= sat_inc(cnt_per, tick);
            if (ctrl.count_high) cnt_high <= sat_inc(cnt_high, tick);
        end
    end

    // Result registers and valid strobe; results hold unless published.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period_out <= '0;
            high_out   <= '0;
            meas_valid <= 1'b0;
        end else begin
            meas_valid <= ctrl.publish;
            if (ctrl.publish) begin
                period_out <= sat_inc(cnt_per, tick);
                high_out   <= cnt_high;
            end
        end
    end

    // Sticky timeout: set on counter saturation, cleared by a result or OFF.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                  timeout <= 1'b0;
        else if (ctrl.set_timeout)   timeout <= 1'b1;
        else if (ctrl.clear_timeout) timeout <= 1'b0;
    end

endmodule

// File: tb/tb_pwm_capture_16bits.sv
// Self-checking bench for pwm_capture_16bits. Expected results come from
// edge times driven by the bench: period = rise-to-rise clk / (div+1),
// high = rise-to-fall clk / (div+1), rounded down.
module tb_pwm_capture_16bits;
    import pwm_capture_16bits_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        pwm_in;
    logic [4:0]  clk_divider;
    pwm_onoff_e  pwm_onoff;
    logic [15:0] period_out;
    logic [15:0] high_out;
    logic        meas_valid;
    logic        timeout;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] per;
        logic [15:0] high;
    } res_t;

    res_t        valid_q[$];
    logic [15:0] last_per  = '0;
    logic [15:0] last_high = '0;

    always #5 clk = ~clk;

    pwm_capture_16bits dut (
        .clk         (clk),
        .reset       (reset),
        .pwm_in      (pwm_in),
        .clk_divider (clk_divider),
        .pwm_onoff   (pwm_onoff),
        .period_out  (period_out),
        .high_out    (high_out),
        .meas_valid  (meas_valid),
        .timeout     (timeout)
    );

    // Record every cycle on which meas_valid is high.
    always @(negedge clk) begin
        if (meas_valid === 1'b1) valid_q.push_back('{period_out, high_out});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Turn capture off, park the pin low, then re-enable with a new divider.
    task automatic restart(input logic [4:0] div);
        pwm_onoff = PWM_OFF;
        pwm_in    = 1'b0;
        cycles(6);
        clk_divider = div;
        valid_q.delete();
        pwm_onoff = PWM_ON;
        cycles(4);
    endtask

    task automatic pwm_cycle(input int h, input int l);
        pwm_in = 1'b1;
        cycles(h);
        pwm_in = 1'b0;
        cycles(l);
    endtask

    // Compare the recorded strobes against n identical expected results.
    task automatic expect_results(input string tag, input int n, input int per, input int high);
        check({tag, "_count"}, valid_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < valid_q.size()) begin
                check({tag, "_period"}, valid_q[i].per, per);
                check({tag, "_high"}, valid_q[i].high, high);
            end
        end
        last_per  = 16'(per);
        last_high = 16'(high);
    endtask

    // n full periods after an arming rise, closed by a final rise.
    task automatic run_capture(input string tag, input int div, input int h, input int l, input int n);
        restart(5'(div));
        repeat (n) pwm_cycle(h, l);
        pwm_in = 1'b1;
        cycles(14);
        expect_results(tag, n, (h + l) / (div + 1), h / (div + 1));
    endtask

    initial begin
        int d, h, l, n;

        reset       = 1'b0;
        pwm_in      = 1'b0;
        clk_divider = '0;
        pwm_onoff   = PWM_OFF;
        #12;
        check("rst_period", period_out, 0);
        check("rst_high", high_out, 0);
        check("rst_valid", meas_valid, 0);
        check("rst_timeout", timeout, 0);
        @(negedge clk);
        reset = 1'b1;
        cycles(3);

        // Directed captures.
        run_capture("div0_100_25", 0, 25, 75, 3);
        run_capture("div3_400_100", 3, 100, 300, 2);

        // Randomized captures.
        for (int k = 0; k < 4; k++) begin
            d = $urandom_range(0, 3);
            h = $urandom_range(8, 60);
            l = $urandom_range(8, 60);
            run_capture("rand", d, h, l, 2);
        end

        // OFF while in LOW: no strobe, results hold, two rises needed after ON.
        restart(0);
        pwm_in = 1'b1;
        cycles(25);
        pwm_in = 1'b0;
        cycles(30);
        pwm_onoff = PWM_OFF;
        cycles(5);
        check("off_no_valid", valid_q.size(), 0);
        check("off_timeout", timeout, 0);
        check("off_hold_period", period_out, last_per);
        check("off_hold_high", high_out, last_high);
        valid_q.delete();
        pwm_onoff = PWM_ON;
        cycles(4);
        pwm_in = 1'b1;
        cycles(25);
        pwm_in = 1'b0;
        cycles(75);
        check("on_one_rise_no_result", valid_q.size(), 0);
        pwm_in = 1'b1;
        cycles(14);
        expect_results("on_second_rise", 1, 100, 25);

        // 2-clk low glitch inside a 50-clk high pulse.
        restart(0);
        pwm_in = 1'b1;
        cycles(20);
        pwm_in = 1'b0;
        cycles(2);
        pwm_in = 1'b1;
        cycles(28);
        pwm_in = 1'b0;
        cycles(50);
        pwm_in = 1'b1;
        cycles(14);
`ifdef PWM_CAP_GLITCH_FILTER_EN
        expect_results("glitch_filtered", 1, 100, 50);
`else
        check("glitch_count", valid_q.size(), 2);
        if (valid_q.size() == 2) begin
            check("glitch_per0", valid_q[0].per, 22);
            check("glitch_high0", valid_q[0].high, 20);
            check("glitch_per1", valid_q[1].per, 78);
            check("glitch_high1", valid_q[1].high, 28);
        end
        last_per  = 16'd78;
        last_high = 16'd28;
`endif

        // Reset pulse in the middle of a high phase.
        run_capture("rst_pre", 0, 40, 60, 1);
        cycles(10);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_period", period_out, 0);
        check("rst_mid_high", high_out, 0);
        check("rst_mid_valid", meas_valid, 0);
        check("rst_mid_timeout", timeout, 0);
        pwm_in = 1'b0;
        cycles(3);
        reset = 1'b1;
        valid_q.delete();
        cycles(4);
        pwm_cycle(40, 60);
        pwm_in = 1'b1;
        cycles(14);
        expect_results("rst_post", 1, 100, 40);

        // Stalled input high: timeout after 2^16-1 ticks, results hold.
        restart(0);
        pwm_in = 1'b1;
        n = 0;
        while (timeout !== 1'b1 && n < 70000) begin
            @(negedge clk);
            n++;
        end
        check("timeout_window", (n >= 65535 && n <= 65555), 1);
        check("timeout_hold_period", period_out, last_per);
        check("timeout_hold_high", high_out, last_high);
        check("timeout_no_valid", valid_q.size(), 0);
        pwm_in = 1'b0;
        cycles(40);
        pwm_in = 1'b1;
        cycles(30);
        pwm_in = 1'b0;
        cycles(70);
        check("timeout_still_set", timeout, 1);
        check("timeout_one_rise_no_result", valid_q.size(), 0);
        pwm_in = 1'b1;
        cycles(14);
        expect_results("timeout_recover", 1, 100, 30);
        check("timeout_cleared", timeout, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
